button_conditioner: RTL and testbench

- Upstream conditioning stage for the board push-buttons (KEY[1:0], active-low, bouncy, asynchronous to the 50 MHz clock).
- Synchronises one raw key, debounces it with a counter-qualified FSM, and emits a clean level plus single-cycle press, release and auto-repeat strobes.
- Downstream consumers (shift register data input, counters, mode selectors) use `pressed` as a level, or `step` as a one-cycle enable.

---
 rtl/button_conditioner_pkg.sv | 31 +++
 rtl/button_conditioner_if.sv | 29 ++
 rtl/button_conditioner_sync_2ff.sv | 40 ++++
 rtl/button_conditioner.sv | 155 +++++++++++++++
 tb/tb_button_conditioner.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Purpose  : Shared types and 50 MHz default timing for the push-button
//            conditioner (debounce FSM states, auto-repeat phases).
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

  // Debounce FSM: two stable states, each with a qualifying check state
  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_PRESS_CHECK   = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_RELEASE_CHECK = 2'd3
  } btn_state_e;

  // Auto-repeat: initial long delay, then a shorter periodic cadence
  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } rpt_phase_e;

  // Defaults for a 50 MHz clock
  localparam int unsigned C_DEBOUNCE_CYCLES_50M      = 1000000;  // 20 ms
  localparam int unsigned C_REPEAT_DELAY_CYCLES_50M  = 25000000; // 0.5 s
  localparam int unsigned C_REPEAT_PERIOD_CYCLES_50M = 5000000;  // 0.1 s
  localparam int unsigned C_CNT_WIDTH_50M            = 25;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_if
// Purpose  : Raw key input plus the conditioned level and strobes of one key.
//            master = whoever drives the key and consumes the strobes,
//            slave  = the conditioner itself.
// Revision : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;

  logic key_n;          // raw button, active-low, asynchronous
  logic pressed;        // debounced level
  logic press_pulse;    // one-cycle strobe on accepted press
  logic release_pulse;  // one-cycle strobe on accepted release
  logic repeat_pulse;   // one-cycle auto-repeat strobe
  logic step;           // press_pulse | repeat_pulse

  modport master (
    output key_n,
    input  pressed, press_pulse, release_pulse, repeat_pulse, step
  );

  modport slave (
    input  key_n,
    output pressed, press_pulse, release_pulse, repeat_pulse, step
  );

endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_conditioner_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a single asynchronous input bit, with
//            a configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  wire logic clock,
  input  wire logic reset_n,
  input  wire logic d,
  output logic      q
);

  logic sync_q1_q, sync_q1_d;
  logic sync_q2_q, sync_q2_d;

  // Next values: plain shift through the two stages
  always_comb begin
    sync_q1_d = d;
    sync_q2_d = sync_q1_q;
  end

  // Synchroniser stages, reset to the idle level of the input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1_q <= RESET_VALUE;
      sync_q2_q <= RESET_VALUE;
    end else begin
      sync_q1_q <= sync_q1_d;
      sync_q2_q <= sync_q2_d;
    end
  end

  assign q = sync_q2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise, debounce and strobe-encode one active-low push
//            button: clean level, press/release strobes and auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = C_DEBOUNCE_CYCLES_50M,
  parameter int unsigned REPEAT_ENABLE        = 1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = C_REPEAT_DELAY_CYCLES_50M,
  parameter int unsigned REPEAT_PERIOD_CYCLES = C_REPEAT_PERIOD_CYCLES_50M,
  parameter int unsigned CNT_WIDTH            = C_CNT_WIDTH_50M
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  button_conditioner_if.slave btn
);

  // Terminal counts; every counter reloads or exits here, so none can wrap
  localparam logic [CNT_WIDTH-1:0] c_deb_last    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_delay_last  = CNT_WIDTH'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_period_last = CNT_WIDTH'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_one         = CNT_WIDTH'(1);

  logic       sync_key_n;
  logic       raw_pressed;

  btn_state_e           state_q, state_d;
  rpt_phase_e           phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;
  logic                 pressed_q, pressed_d;
  logic                 press_pulse_q, press_pulse_d;
  logic                 release_pulse_q, release_pulse_d;
  logic                 repeat_pulse_q, repeat_pulse_d;
  logic                 step_q, step_d;

  // The key is only ever sampled through this synchroniser (idles released)
  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (btn.key_n),
    .q       (sync_key_n)
  );

  assign raw_pressed = !sync_key_n;

  // Debounce FSM next-state, counters and strobe generation
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    cnt_d           = cnt_q;
    rpt_cnt_d       = rpt_cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    repeat_pulse_d  = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (raw_pressed) begin
          state_d = ST_PRESS_CHECK;
          cnt_d   = '0;
        end
      end

      ST_PRESS_CHECK: begin
        if (!raw_pressed) begin
          state_d = ST_RELEASED;          // bounce, no strobe
        end else if (cnt_q == c_deb_last) begin
          state_d       = ST_PRESSED;
          press_pulse_d = 1'b1;
          pressed_d     = 1'b1;
          rpt_cnt_d     = '0;
          phase_d       = PH_DELAY;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end

      ST_PRESSED: begin
        if (!raw_pressed) begin
          state_d = ST_RELEASE_CHECK;
          cnt_d   = '0;
        end else if (REPEAT_ENABLE != 0) begin
          // Repeat timing only advances while stably held
          if (((phase_q == PH_DELAY)  && (rpt_cnt_q == c_delay_last)) ||
              ((phase_q == PH_PERIOD) && (rpt_cnt_q == c_period_last))) begin
            repeat_pulse_d = 1'b1;
            rpt_cnt_d      = '0;
            phase_d        = PH_PERIOD;
          end else begin
            rpt_cnt_d = rpt_cnt_q + c_one;
          end
        end
      end

      ST_RELEASE_CHECK: begin
        if (raw_pressed) begin
          state_d = ST_PRESSED;           // glitch; repeat phase is kept
        end else if (cnt_q == c_deb_last) begin
          state_d         = ST_RELEASED;
          release_pulse_d = 1'b1;
          pressed_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end

      default: begin
        state_d = ST_RELEASED;
      end
    endcase

    step_d = press_pulse_d | repeat_pulse_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_RELEASED;
      phase_q         <= PH_DELAY;
      cnt_q           <= '0;
      rpt_cnt_q       <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      step_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      cnt_q           <= cnt_d;
      rpt_cnt_q       <= rpt_cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      repeat_pulse_q  <= repeat_pulse_d;
      step_q          <= step_d;
    end
  end

  assign btn.pressed       = pressed_q;
  assign btn.press_pulse   = press_pulse_q;
  assign btn.release_pulse = release_pulse_q;
  assign btn.repeat_pulse  = repeat_pulse_q;
  assign btn.step          = step_q;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. Three instances share
//            one key: nominal, auto-repeat disabled, and single-cycle debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N = 3;
  localparam int P_DEB[N]    = '{4, 4, 1};
  localparam int P_EN[N]     = '{1, 0, 1};
  localparam int P_DELAY[N]  = '{10, 10, 2};
  localparam int P_PERIOD[N] = '{3, 3, 1};

  logic clock;
  logic reset_n;
  logic key_n;

  button_conditioner_if bus0 ();
  button_conditioner_if bus1 ();
  button_conditioner_if bus2 ();

  assign bus0.key_n = key_n;
  assign bus1.key_n = key_n;
  assign bus2.key_n = key_n;

  button_conditioner #(
    .DEBOUNCE_CYCLES(P_DEB[0]), .REPEAT_ENABLE(P_EN[0]),
    .REPEAT_DELAY_CYCLES(P_DELAY[0]), .REPEAT_PERIOD_CYCLES(P_PERIOD[0]), .CNT_WIDTH(8)
  ) u_dut0 (.clock(clock), .reset_n(reset_n), .btn(bus0));

  button_conditioner #(
    .DEBOUNCE_CYCLES(P_DEB[1]), .REPEAT_ENABLE(P_EN[1]),
    .REPEAT_DELAY_CYCLES(P_DELAY[1]), .REPEAT_PERIOD_CYCLES(P_PERIOD[1]), .CNT_WIDTH(8)
  ) u_dut1 (.clock(clock), .reset_n(reset_n), .btn(bus1));

  button_conditioner #(
    .DEBOUNCE_CYCLES(P_DEB[2]), .REPEAT_ENABLE(P_EN[2]),
    .REPEAT_DELAY_CYCLES(P_DELAY[2]), .REPEAT_PERIOD_CYCLES(P_PERIOD[2]), .CNT_WIDTH(8)
  ) u_dut2 (.clock(clock), .reset_n(reset_n), .btn(bus2));

  // Observed outputs packed as {pressed, press, release, repeat, step}
  logic [4:0] obs [N];
  assign obs[0] = {bus0.pressed, bus0.press_pulse, bus0.release_pulse, bus0.repeat_pulse, bus0.step};
  assign obs[1] = {bus1.pressed, bus1.press_pulse, bus1.release_pulse, bus1.repeat_pulse, bus1.step};
  assign obs[2] = {bus2.pressed, bus2.press_pulse, bus2.release_pulse, bus2.repeat_pulse, bus2.step};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Key samples reach the debouncer two edges late. A level change is
  // accepted once the sampled key has disagreed with the current level on
  // DEB+1 consecutive edges. Auto-repeat counts the edges on which the key
  // was stably held (level high, no disagreement now or on the prior edge).
  bit         k1, k2;
  bit         lvl  [N];
  int         run  [N];
  int         nact [N];
  logic [4:0] exp_o[N];

  task automatic model_reset();
    k1 = 1'b1;
    k2 = 1'b1;
    for (int i = 0; i < N; i++) begin
      lvl[i]   = 1'b0;
      run[i]   = 0;
      nact[i]  = 0;
      exp_o[i] = 5'b0;
    end
  endtask

  task automatic model_step();
    bit raw;
    bit pp, rp, rep;
    int prev;
    if (!reset_n) begin
      model_reset();
      return;
    end
    raw = !k2;
    for (int i = 0; i < N; i++) begin
      pp = 1'b0; rp = 1'b0; rep = 1'b0;
      prev = run[i];
      run[i] = (raw != lvl[i]) ? run[i] + 1 : 0;
      if (run[i] == P_DEB[i] + 1) begin
        if (!lvl[i]) begin
          lvl[i]  = 1'b1;
          pp      = 1'b1;
          nact[i] = 0;
        end else begin
          lvl[i] = 1'b0;
          rp     = 1'b1;
        end
        run[i] = 0;
      end else if (lvl[i] && prev == 0 && run[i] == 0) begin
        nact[i]++;
        if (P_EN[i] != 0 &&
            (nact[i] == P_DELAY[i] ||
             (nact[i] > P_DELAY[i] && ((nact[i] - P_DELAY[i]) % P_PERIOD[i]) == 0)))
          rep = 1'b1;
      end
      exp_o[i] = {lvl[i], pp, rp, rep, pp | rep};
    end
    k2 = k1;
    k1 = key_n;
  endtask

  // One clock: model advances on the rising edge, DUT compared on the falling
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    for (int i = 0; i < N; i++)
      check($sformatf("dut%0d_cyc%0d", i, cyc), {27'b0, obs[i]}, {27'b0, exp_o[i]});
    cyc++;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("%s_dut%0d", tag, i), {27'b0, obs[i]}, 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;   // deasserted at a falling edge
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int first_press;
  int rep_cnt, step_cnt;

  initial begin
    key_n   = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < N; i++)
      check($sformatf("reset_dut%0d", i), {27'b0, obs[i]}, 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    repeat (4) cycle();

    // Clean press: key low before edge 0, strobe expected after edge 6
    key_n = 1'b0;
    first_press = -1;
    rep_cnt = 0;
    step_cnt = 0;
    for (int e = 0; e <= 36; e++) begin
      cycle();
      if (first_press < 0 && bus0.press_pulse) first_press = e;
      if (e > 6 && bus0.repeat_pulse) rep_cnt++;
      if (e > 6 && bus0.step) step_cnt++;
    end
    check("press_latency", first_press, 32'd6);
    check("repeat_count_30", rep_cnt, 32'd7);
    check("step_count_30", step_cnt, 32'd7);
    key_n = 1'b1;
    repeat (12) cycle();

    // Bounce shorter than the debounce window
    key_n = 1'b0; repeat (3) cycle();
    key_n = 1'b1; repeat (2) cycle();
    key_n = 1'b0; repeat (2) cycle();
    key_n = 1'b1; repeat (12) cycle();

    // Hold with a 2-cycle release glitch, then clean release
    key_n = 1'b0; repeat (20) cycle();
    key_n = 1'b1; repeat (2) cycle();
    key_n = 1'b0; repeat (25) cycle();
    key_n = 1'b1; repeat (12) cycle();

    // Long hold exercises the repeat-disabled instance
    key_n = 1'b0; repeat (110) cycle();
    key_n = 1'b1; repeat (12) cycle();

    // Reset mid-press, key still held afterwards
    key_n = 1'b0; repeat (15) cycle();
    async_reset("midpress_reset");
    first_press = -1;
    for (int e = 0; e < 12; e++) begin
      cycle();
      if (first_press < 0 && bus0.press_pulse) first_press = e;
    end
    check("press_after_reset", first_press, 32'd6);
    key_n = 1'b1; repeat (12) cycle();

    // Randomised segments of press/release/bounce with occasional resets
    for (int s = 0; s < 300; s++) begin
      int len;
      key_n = ~key_n;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 6);
      repeat (len) cycle();
      if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
    end
    key_n = 1'b1;
    repeat (12) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_button_conditioner
`default_nettype wire
